key_scan_ctrl: RTL and testbench
================================

KEY_SCAN_CTRL -- requirements
Module: key_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50000, meaning Clk cycles each row is driven (1 ms at 50 MHz); legal range 16..2^20-1.
REQ-002 The block SHALL have parameter DEB_SCANS, default 20, meaning consecutive identical full-matrix frames required to accept a key state; legal range 1..255.
REQ-003 The block SHALL have port Clk, input, 1, system clock, 50 MHz nominal.
REQ-004 The block SHALL have port nRst, input, 1, reset, asynchronous, active-low.
REQ-005 The block SHALL have port nRow, output, 4, active-low row drive to the 4x4 keypad; at most one bit low.
REQ-006 The block SHALL have port nCol, input, 4, active-low column sense from the keypad, asynchronous, externally pulled up.
REQ-007 The block SHALL have port Ev_Valid, output, 1, meaning a key event is presented.
REQ-008 The block SHALL have port Ev_Ready, input, 1, meaning the consumer accepts the event.
REQ-009 The block SHALL have port Ev_Code, output, 4, meaning key index = row*4+col.
REQ-010 The block SHALL have port Ev_Press, output, 1, meaning 1 = press event and 0 = release event.
REQ-011 The block SHALL have port Ov_Err, output, 1, sticky flag for an event lost to a full queue.
REQ-012 The block SHALL have port Clr_Err, input, 1, synchronous clear of Ov_Err.

Function
REQ-013 nCol SHALL pass through a 2-flop synchronizer, and only the synchronized value SHALL be sampled.
REQ-014 The row sequencer SHALL drive row r low (nRow = ~(1<<r)) for exactly SCAN_DIV cycles, then advance r = (r+1) mod 4.
REQ-015 On the last dwell cycle of row r, the 4 synchronized column bits SHALL be captured, inverted, into raw[4r+c] (1 = pressed).
REQ-016 Completion of row 3 SHALL define a frame; frame rate SHALL be Clk/(4*SCAN_DIV).
REQ-017 At frame end, if raw equals prev_frame, stable_cnt SHALL increment, saturating at DEB_SCANS; otherwise stable_cnt SHALL be cleared to 0 and prev_frame SHALL load raw.
REQ-018 The cycle in which stable_cnt reaches DEB_SCANS SHALL start the emit phase; later saturated frames SHALL NOT restart it.
REQ-019 The emit FSM SHALL have states IDLE and EMIT; IDLE->EMIT on the start condition of REQ-018.
REQ-020 In EMIT, the FSM SHALL visit key index k = 0..15, one index per cycle, then return to IDLE after k = 15 (16 cycles).
REQ-021 At index k, if prev_frame[k] != deb[k], the block SHALL push {k, prev_frame[k]} to the queue and set deb[k] = prev_frame[k].
REQ-022 Events from one frame SHALL therefore be emitted in ascending key index order.
REQ-023 The scan sequencer SHALL continue running during EMIT; SCAN_DIV >= 16 guarantees EMIT completes before the next frame end.
REQ-024 The event queue SHALL be a 4-entry FIFO with Ev_Valid = not empty, and Ev_Code/Ev_Press driven from the head entry.
REQ-025 A pop SHALL occur when Ev_Valid and Ev_Ready are both high at a rising edge.
REQ-026 Head data and Ev_Valid SHALL be held stable until popped.
REQ-027 On a push when the FIFO is full with no pop in the same cycle, the event SHALL be dropped, deb[k] SHALL still update, and Ov_Err SHALL be set.
REQ-028 On a simultaneous push and pop when full, both SHALL occur with no drop and no Ov_Err.
REQ-029 On a simultaneous push and pop when empty, the pushed entry SHALL be stored and Ev_Valid SHALL be 1 on the next cycle.
REQ-030 Clr_Err SHALL clear Ov_Err on the next edge; if an overflow occurs in the same cycle, set SHALL win.
REQ-031 Multi-key presses SHALL be reported as scanned; ghosting SHALL NOT be suppressed.
REQ-032 Latency from the stable contact of a key to Ev_Valid SHALL be at most (DEB_SCANS+2)*4*SCAN_DIV + 20 cycles.

Reset
REQ-033 While nRst = 0, the block SHALL hold: nRow = 4'hF, r = 0, dwell counter = 0, raw/prev_frame/deb = 0, stable_cnt = 0, FSM = IDLE, FIFO empty, Ev_Valid = 0, Ev_Code = 0, Ev_Press = 0, Ov_Err = 0.
REQ-034 The first edge after reset release SHALL drive nRow = 4'hE.
REQ-035 Reset mid-EMIT or mid-dwell SHALL discard all queued and pending events, with no events issued for the interrupted frame.

Verification
REQ-036 The bench SHALL cover (SCAN_DIV=16, DEB_SCANS=2) key 6 held pressed -> exactly one event Code=6, Press=1, and no further events while held.
REQ-037 The bench SHALL cover key 6 released after REQ-036 -> one event Code=6, Press=0.
REQ-038 The bench SHALL cover key 5 toggling every frame for 10 frames, then stable -> no event during toggling and one press event after 2 stable frames.
REQ-039 The bench SHALL cover keys 15, 0 and 9 pressed in the same frame -> events emitted in order 0, 9, 15, each with Press=1.
REQ-040 The bench SHALL cover Ev_Ready=0 with 6 keys pressed together -> 4 events queued, Ov_Err=1, and deb showing all 6 keys pressed; on later release of all 6, only the 4 queued press events are read first.
REQ-041 The bench SHALL cover nRst asserted during EMIT -> Ev_Valid=0 and nRow=4'hF immediately, with no stale events after release.

Source files
------------

// File: rtl/key_scan_ctrl.sv
// rtl/key_scan_ctrl.sv - 4x4 keypad row scanner with frame debounce and press/release event queue
module key_scan_ctrl #(
   parameter int unsigned SCAN_DIV  = 50000,
   parameter int unsigned DEB_SCANS = 20
) (
   input  logic       Clk,
   input  logic       nRst,
   output logic [3:0] nRow,
   input  logic [3:0] nCol,
   output logic       Ev_Valid,
   input  logic       Ev_Ready,
   output logic [3:0] Ev_Code,
   output logic       Ev_Press,
   output logic       Ov_Err,
   input  logic       Clr_Err
);

   localparam logic [19:0] DWELL_LAST = 20'(SCAN_DIV - 1);
   localparam logic [7:0]  DEB_MAX    = 8'(DEB_SCANS);
   localparam logic [7:0]  DEB_PRE    = 8'(DEB_SCANS - 1);

   typedef enum logic {S_IDLE, S_EMIT} state_t;

   logic [3:0]  r_col_s1, r_col_s2;
   logic [1:0]  r_row;
   logic [19:0] r_dwell;
   logic [3:0]  r_nrow;
   logic [15:0] r_raw, r_prev, r_deb;
   logic [7:0]  r_stable;
   state_t      r_state, w_state_next;
   logic [3:0]  r_k;

   logic [4:0]  r_mem [0:3];
   logic [1:0]  r_wr_ptr, r_rd_ptr;
   logic [2:0]  r_count;
   logic        r_ov_err;

   logic        w_dwell_last, w_frame_end, w_same, w_start;
   logic [1:0]  w_row_next;
   logic [15:0] w_raw_new;
   logic        w_push;
   logic [4:0]  w_push_data;
   logic        w_full, w_empty, w_pop, w_wr_en, w_ovf;
   logic [4:0]  w_head;

   assign w_dwell_last = (r_dwell == DWELL_LAST);
   assign w_row_next   = w_dwell_last ? r_row + 2'd1 : r_row;
   assign w_frame_end  = w_dwell_last && (r_row == 2'd3);
   assign w_same       = (w_raw_new == r_prev);
   // Only the frame that brings the counter up to DEB_SCANS starts an emit pass.
   assign w_start      = w_frame_end && w_same && (r_stable == DEB_PRE);

   always_comb begin
      w_raw_new = r_raw;
      w_raw_new[{r_row, 2'b00} +: 4] = ~r_col_s2;
   end

   always_ff @(posedge Clk or negedge nRst) begin
      if (!nRst) begin
         r_col_s1 <= 4'hF;
         r_col_s2 <= 4'hF;
         r_row    <= 2'd0;
         r_dwell  <= 20'd0;
         r_nrow   <= 4'hF;
         r_raw    <= 16'd0;
         r_prev   <= 16'd0;
         r_stable <= 8'd0;
      end else begin
         r_col_s1 <= nCol;
         r_col_s2 <= r_col_s1;
         r_dwell  <= w_dwell_last ? 20'd0 : r_dwell + 20'd1;
         r_row    <= w_row_next;
         r_nrow   <= ~(4'b0001 << w_row_next);
         if (w_dwell_last)
            r_raw <= w_raw_new;
         if (w_frame_end) begin
            if (w_same) begin
               if (r_stable < DEB_MAX)
                  r_stable <= r_stable + 8'd1;
            end else begin
               r_stable <= 8'd0;
               r_prev   <= w_raw_new;
            end
         end
      end
   end

   always_ff @(posedge Clk or negedge nRst) begin
      if (!nRst) begin
         r_state <= S_IDLE;
         r_k     <= 4'd0;
      end else begin
         r_state <= w_state_next;
         r_k     <= (r_state == S_EMIT) ? r_k + 4'd1 : 4'd0;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_start) w_state_next = S_EMIT;
         S_EMIT:  if (r_k == 4'd15) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_push      = 1'b0;
      w_push_data = {r_k, r_prev[r_k]};
      if (r_state == S_EMIT && r_prev[r_k] != r_deb[r_k])
         w_push = 1'b1;
   end

   // Debounced state follows the frame even when the event itself is dropped.
   always_ff @(posedge Clk or negedge nRst) begin
      if (!nRst)
         r_deb <= 16'd0;
      else if (w_push)
         r_deb[r_k] <= r_prev[r_k];
   end

   assign w_full  = (r_count == 3'd4);
   assign w_empty = (r_count == 3'd0);
   assign w_pop   = !w_empty && Ev_Ready;
   assign w_wr_en = w_push && (!w_full || w_pop);
   assign w_ovf   = w_push && w_full && !w_pop;

   always_ff @(posedge Clk or negedge nRst) begin
      if (!nRst) begin
         for (int i = 0; i < 4; i++)
            r_mem[i] <= 5'd0;
         r_wr_ptr <= 2'd0;
         r_rd_ptr <= 2'd0;
         r_count  <= 3'd0;
      end else begin
         if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_push_data;
            r_wr_ptr        <= r_wr_ptr + 2'd1;
         end
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 2'd1;
         case ({w_wr_en, w_pop})
            2'b10:   r_count <= r_count + 3'd1;
            2'b01:   r_count <= r_count - 3'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge nRst) begin
      if (!nRst)
         r_ov_err <= 1'b0;
      else if (w_ovf)
         r_ov_err <= 1'b1;
      else if (Clr_Err)
         r_ov_err <= 1'b0;
   end

   assign w_head   = r_mem[r_rd_ptr];
   assign nRow     = r_nrow;
   assign Ev_Valid = !w_empty;
   assign Ev_Code  = Ev_Valid ? w_head[4:1] : 4'd0;
   assign Ev_Press = Ev_Valid & w_head[0];
   assign Ov_Err   = r_ov_err;

endmodule

// File: tb/tb_key_scan_ctrl.sv
// tb/tb_key_scan_ctrl.sv - directed bench for key_scan_ctrl with a keypad matrix model
module tb_key_scan_ctrl;

   logic        Clk = 1'b0;
   logic        nRst;
   logic [3:0]  nRow, nCol, Ev_Code;
   logic        Ev_Valid, Ev_Ready, Ev_Press, Ov_Err, Clr_Err;
   logic [15:0] keys;
   logic [4:0]  ev_q [$];
   int          checks = 0;
   int          failures = 0;

   always #5 Clk = ~Clk;

   key_scan_ctrl #(.SCAN_DIV(16), .DEB_SCANS(2)) dut (
      .Clk(Clk), .nRst(nRst), .nRow(nRow), .nCol(nCol),
      .Ev_Valid(Ev_Valid), .Ev_Ready(Ev_Ready), .Ev_Code(Ev_Code),
      .Ev_Press(Ev_Press), .Ov_Err(Ov_Err), .Clr_Err(Clr_Err)
   );

   // Pressed key shorts its row line to its column line.
   always_comb begin
      nCol = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!nRow[r] && keys[r*4+c])
               nCol[c] = 1'b0;
   end

   always @(negedge Clk)
      if (nRst && Ev_Valid && Ev_Ready)
         ev_q.push_back({Ev_Code, Ev_Press});

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic wait_ev(input string tag, input int n, input int budget);
      int i = 0;
      while (ev_q.size() < n && i < budget) begin
         cyc(1);
         i++;
      end
      chk({tag, "_count"}, ev_q.size(), n);
   endtask

   task automatic chk_next(input string tag, input logic [4:0] exp);
      logic [31:0] obs;
      obs = 32'hDEAD;
      if (ev_q.size() > 0)
         obs = {27'd0, ev_q.pop_front()};
      chk(tag, obs, {27'd0, exp});
   endtask

   initial begin
      keys = 16'd0; Ev_Ready = 1'b1; Clr_Err = 1'b0; nRst = 1'b0;
      cyc(3);
      chk("rst_nrow", nRow, 4'hF);
      chk("rst_valid", Ev_Valid, 1'b0);
      chk("rst_code", Ev_Code, 4'd0);
      chk("rst_press", Ev_Press, 1'b0);
      chk("rst_ovf", Ov_Err, 1'b0);

      nRst = 1'b1;
      cyc(1);
      chk("row0_first", nRow, 4'hE);
      cyc(14);
      chk("row0_dwell", nRow, 4'hE);
      cyc(1);
      chk("row1_start", nRow, 4'hD);
      cyc(400);
      chk("idle_noev", ev_q.size(), 0);

      keys[6] = 1'b1;
      wait_ev("k6p", 1, 600);
      chk_next("k6p_ev", 5'b01101);
      cyc(300);
      chk("k6_hold", ev_q.size(), 0);

      keys[6] = 1'b0;
      wait_ev("k6r", 1, 600);
      chk_next("k6r_ev", 5'b01100);
      cyc(200);
      chk("k6r_once", ev_q.size(), 0);

      for (int i = 0; i < 10; i++) begin
         keys[5] = ~keys[5];
         cyc(64);
      end
      chk("k5_toggle", ev_q.size(), 0);
      keys[5] = 1'b1;
      wait_ev("k5p", 1, 600);
      chk_next("k5p_ev", 5'b01011);
      cyc(100);
      chk("k5p_once", ev_q.size(), 0);
      keys[5] = 1'b0;
      wait_ev("k5r", 1, 600);
      chk_next("k5r_ev", 5'b01010);

      keys = 16'h8201;
      wait_ev("multi_p", 3, 600);
      chk_next("multi_p0", 5'b00001);
      chk_next("multi_p9", 5'b10011);
      chk_next("multi_p15", 5'b11111);
      cyc(100);
      chk("multi_p_once", ev_q.size(), 0);
      keys = 16'h0000;
      wait_ev("multi_r", 3, 600);
      chk_next("multi_r0", 5'b00000);
      chk_next("multi_r9", 5'b10010);
      chk_next("multi_r15", 5'b11110);

      Ev_Ready = 1'b0;
      keys = 16'h019E;
      cyc(600);
      chk("ovf_valid", Ev_Valid, 1'b1);
      chk("ovf_head_code", Ev_Code, 4'd1);
      chk("ovf_head_press", Ev_Press, 1'b1);
      chk("ovf_flag", Ov_Err, 1'b1);
      Ev_Ready = 1'b1;
      wait_ev("ovf_drain", 4, 50);
      chk_next("ovf_d1", 5'b00011);
      chk_next("ovf_d2", 5'b00101);
      chk_next("ovf_d3", 5'b00111);
      chk_next("ovf_d4", 5'b01001);
      cyc(100);
      chk("ovf_dropped", ev_q.size(), 0);
      chk("ovf_sticky", Ov_Err, 1'b1);
      Clr_Err = 1'b1;
      cyc(1);
      Clr_Err = 1'b0;
      chk("ovf_clear", Ov_Err, 1'b0);
      keys = 16'h0000;
      wait_ev("ovf_rel", 6, 600);
      chk_next("ovf_r1", 5'b00010);
      chk_next("ovf_r2", 5'b00100);
      chk_next("ovf_r3", 5'b00110);
      chk_next("ovf_r4", 5'b01000);
      chk_next("ovf_r7", 5'b01110);
      chk_next("ovf_r8", 5'b10000);
      chk("ovf_rel_noerr", Ov_Err, 1'b0);

      keys = 16'h4004;
      for (int i = 0; i < 600; i++) begin
         cyc(1);
         if (Ev_Valid) break;
      end
      chk("rstemit_seen", Ev_Valid, 1'b1);
      nRst = 1'b0;
      #1;
      chk("rstemit_valid", Ev_Valid, 1'b0);
      chk("rstemit_nrow", nRow, 4'hF);
      keys = 16'h0000;
      cyc(5);
      nRst = 1'b1;
      cyc(600);
      chk("rstemit_nostale", ev_q.size(), 0);
      chk("rstemit_ovf", Ov_Err, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
